// File: rtl/est_pkg.sv
// Shared definitions for the Kalman measurement-update stage.
// Default word geometry, FSM state encoding, and the two numeric helpers
// (result fitting and product-sum alignment).
// Build option: define EST_UPD_SAT_EN to make fit() saturate; otherwise it wraps.
package est_pkg;

  localparam int EST_N    = 20;
  localparam int EST_FRAC = 10;

  // Sequencer states; encodings 6 and 7 are illegal and fall back to IDLE.
  typedef logic [2:0] est_state_t;
  localparam est_state_t S_IDLE  = 3'd0;
  localparam est_state_t S_INNOV = 3'd1;
  localparam est_state_t S_LOAD0 = 3'd2;
  localparam est_state_t S_CAP0  = 3'd3;
  localparam est_state_t S_LOAD1 = 3'd4;
  localparam est_state_t S_CAP1  = 3'd5;

  // Fit a signed value (carried in a 64-bit container) into n bits.
  // The caller keeps the low n bits of the result; n must be 2..32.
  function automatic logic signed [63:0] fit(input logic signed [63:0] v, input int n);
`ifdef EST_UPD_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
`else
    // Two's-complement wrap: keep the low n bits, sign-extended.
    return (v <<< (64 - n)) >>> (64 - n);
`endif
  endfunction

  // Align a 2N-bit full-precision product sum back to the N-bit word:
  // drop the low frac bits (floor toward -inf). Caller keeps the low N bits.
  function automatic logic signed [63:0] trunc_2N_to_N(input logic signed [63:0] sum,
                                                       input int frac);
    return sum >>> frac;
  endfunction

endpackage

// File: rtl/est_innov_sub.sv
// Registered two-lane innovation subtractor: y = fit(z - zh), with the
// difference formed at N+1 bits so the overflow is visible to fit().
// Lanes update only while en is high; otherwise they hold.
module est_innov_sub
  import est_pkg::*;
#(
  parameter int N = EST_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] z0,
  input  logic [N-1:0] zh0,
  input  logic [N-1:0] z1,
  input  logic [N-1:0] zh1,
  output logic [N-1:0] y0,
  output logic [N-1:0] y1
);

  logic signed [N:0] diff0;
  logic signed [N:0] diff1;

  assign diff0 = $signed({z0[N-1], z0}) - $signed({zh0[N-1], zh0});
  assign diff1 = $signed({z1[N-1], z1}) - $signed({zh1[N-1], zh1});

  // Capture both fitted differences when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      y0 <= '0;
      y1 <= '0;
    end else if (en) begin
      y0 <= N'(fit(64'(diff0), N));
      y1 <= N'(fit(64'(diff1), N));
    end
  end

endmodule

// File: rtl/est_update_serial.sv
// Kalman measurement update: Y = z - zh, X = x + K*Y for a 2-element state.
// One row of K*Y is formed per pass with two shared multipliers and a 2N adder;
// the two rows are processed serially (IDLE->INNOV->LOAD0->CAP0->LOAD1->CAP1).
// Build option: EST_UPD_SAT_EN selects saturating fit(); default wraps.
// Handshake: start is a request taken only in IDLE (inputs latched that cycle);
// busy is high outside IDLE; done pulses for one cycle when X10 is valid, and
// that cycle is already IDLE so a new start there is accepted.
module est_update_serial
  import est_pkg::*;
#(
  parameter int N    = EST_N,
  parameter int FRAC = EST_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] k00,
  input  logic [N-1:0] k01,
  input  logic [N-1:0] k10,
  input  logic [N-1:0] k11,
  input  logic [N-1:0] x00,
  input  logic [N-1:0] x10,
  input  logic [N-1:0] z00,
  input  logic [N-1:0] z10,
  input  logic [N-1:0] zh00,
  input  logic [N-1:0] zh10,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Y00,
  output logic [N-1:0] Y10,
  output logic [N-1:0] X00,
  output logic [N-1:0] X10
);

  est_state_t state;
  est_state_t state_nxt;

  logic [N-1:0] k00_q, k01_q, k10_q, k11_q;
  logic [N-1:0] x00_q, x10_q;
  logic [N-1:0] z00_q, z10_q, zh00_q, zh10_q;

  logic [N-1:0] op_k0, op_y0, op_k1, op_y1;

  logic signed [2*N-1:0] prod0;
  logic signed [2*N-1:0] prod1;
  logic signed [2*N-1:0] prod_sum;
  logic signed [N-1:0]   s;
  logic [N-1:0]          x_sel;
  logic signed [N:0]     x_sum;
  logic [N-1:0]          x_fit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: fixed walk through the two rows; illegal codes go to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = start ? S_INNOV : S_IDLE;
      S_INNOV: state_nxt = S_LOAD0;
      S_LOAD0: state_nxt = S_CAP0;
      S_CAP0:  state_nxt = S_LOAD1;
      S_LOAD1: state_nxt = S_CAP1;
      S_CAP1:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Latch the operation's inputs on an accepted start so callers may move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      k00_q <= '0; k01_q <= '0; k10_q <= '0; k11_q <= '0;
      x00_q <= '0; x10_q <= '0;
      z00_q <= '0; z10_q <= '0; zh00_q <= '0; zh10_q <= '0;
    end else if (state == S_IDLE && start) begin
      k00_q <= k00; k01_q <= k01; k10_q <= k10; k11_q <= k11;
      x00_q <= x00; x10_q <= x10;
      z00_q <= z00; z10_q <= z10; zh00_q <= zh00; zh10_q <= zh10;
    end
  end

  est_innov_sub #(
    .N (N)
  ) u_innov (
    .clk (clk),
    .rst (rst),
    .en  (state == S_INNOV),
    .z0  (z00_q),
    .zh0 (zh00_q),
    .z1  (z10_q),
    .zh1 (zh10_q),
    .y0  (Y00),
    .y1  (Y10)
  );

  // Multiplier operand registers: row 0 of K in LOAD0, row 1 in LOAD1.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_k0 <= '0; op_y0 <= '0; op_k1 <= '0; op_y1 <= '0;
    end else if (state == S_LOAD0) begin
      op_k0 <= k00_q; op_y0 <= Y00; op_k1 <= k01_q; op_y1 <= Y10;
    end else if (state == S_LOAD1) begin
      op_k0 <= k10_q; op_y0 <= Y00; op_k1 <= k11_q; op_y1 <= Y10;
    end
  end

  // Shared datapath: two full-precision products, 2N sum (wraps at 2N),
  // floor-aligned to N bits, then added to the row's state at N+1 bits.
  assign prod0    = $signed(op_k0) * $signed(op_y0);
  assign prod1    = $signed(op_k1) * $signed(op_y1);
  assign prod_sum = prod0 + prod1;
  assign s        = N'(trunc_2N_to_N(64'(prod_sum), FRAC));
  assign x_sel    = (state == S_CAP0) ? x00_q : x10_q;
  assign x_sum    = $signed({x_sel[N-1], x_sel}) + $signed({s[N-1], s});
  assign x_fit    = N'(fit(64'(x_sum), N));

  // Corrected-state outputs and the completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      X00  <= '0;
      X10  <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == S_CAP1);
      if (state == S_CAP0) X00 <= x_fit;
      if (state == S_CAP1) X10 <= x_fit;
    end
  end

endmodule

// File: tb/tb_est_update_serial.sv
// Directed bench for est_update_serial. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Overflow expectations follow
// EST_UPD_SAT_EN.
module tb_est_update_serial;

  localparam int N = 20;

`ifdef EST_UPD_SAT_EN
  localparam int OVF_Y00 = 524287;
  localparam int OVF_Y10 = -524288;
  localparam int OVF_X00 = 524287;
`else
  localparam int OVF_Y00 = -1;
  localparam int OVF_Y10 = 524287;
  localparam int OVF_X00 = -523265;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] k00 = '0, k01 = '0, k10 = '0, k11 = '0;
  logic [N-1:0] x00 = '0, x10 = '0;
  logic [N-1:0] z00 = '0, z10 = '0, zh00 = '0, zh10 = '0;
  logic         busy, done;
  logic [N-1:0] Y00, Y10, X00, X10;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  est_update_serial dut (
    .clk  (clk),  .rst  (rst),  .start (start),
    .k00  (k00),  .k01  (k01),  .k10   (k10),  .k11 (k11),
    .x00  (x00),  .x10  (x10),
    .z00  (z00),  .z10  (z10),  .zh00  (zh00), .zh10 (zh10),
    .busy (busy), .done (done),
    .Y00  (Y00),  .Y10  (Y10),  .X00   (X00),  .X10 (X10)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input int a00, input int a01, input int a10, input int a11,
                       input int xa, input int xb, input int za, input int zb,
                       input int zha, input int zhb);
    k00 = 20'(a00); k01 = 20'(a01); k10 = 20'(a10); k11 = 20'(a11);
    x00 = 20'(xa);  x10 = 20'(xb);
    z00 = 20'(za);  z10 = 20'(zb);  zh00 = 20'(zha); zh10 = 20'(zhb);
  endtask

  // Pulse start for one cycle; returns at the falling edge after the accepting edge.
  task automatic start_op();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges until done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %0b expected 0", done); end
    vec_cnt++; if (Y00 !== 20'd0) begin err_cnt++; $display("FAIL rst_y00: got %0d expected 0", $signed(Y00)); end
    vec_cnt++; if (Y10 !== 20'd0) begin err_cnt++; $display("FAIL rst_y10: got %0d expected 0", $signed(Y10)); end
    vec_cnt++; if (X00 !== 20'd0) begin err_cnt++; $display("FAIL rst_x00: got %0d expected 0", $signed(X00)); end
    vec_cnt++; if (X10 !== 20'd0) begin err_cnt++; $display("FAIL rst_x10: got %0d expected 0", $signed(X10)); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int busy_cnt, done_cnt, done_at;
    logic [N-1:0] y00_at1, x00_at2, x00_at3;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    y00_at1 = '0; x00_at2 = '0; x00_at3 = '0;
    drive(1024, 0, 0, 1024, 0, 0, 2048, 1024, 1024, 512);
    start_op();
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin done_cnt++; done_at = i; end
      if (i == 1) y00_at1 = Y00;
      if (i == 2) x00_at2 = X00;
      if (i == 3) x00_at3 = X00;
      @(negedge clk);
    end
    vec_cnt++; if (busy_cnt !== 5) begin err_cnt++; $display("FAIL id_busy_cycles: got %0d expected 5", busy_cnt); end
    vec_cnt++; if (done_cnt !== 1) begin err_cnt++; $display("FAIL id_done_pulses: got %0d expected 1", done_cnt); end
    vec_cnt++; if (done_at !== 5) begin err_cnt++; $display("FAIL id_done_latency: got %0d expected 5", done_at); end
    vec_cnt++; if (y00_at1 !== 20'd1024) begin err_cnt++; $display("FAIL id_y00_early: got %0d expected 1024", $signed(y00_at1)); end
    vec_cnt++; if (x00_at2 !== 20'd0) begin err_cnt++; $display("FAIL id_x00_not_yet: got %0d expected 0", $signed(x00_at2)); end
    vec_cnt++; if (x00_at3 !== 20'd1024) begin err_cnt++; $display("FAIL id_x00_early: got %0d expected 1024", $signed(x00_at3)); end
    vec_cnt++; if (Y00 !== 20'd1024) begin err_cnt++; $display("FAIL id_y00: got %0d expected 1024", $signed(Y00)); end
    vec_cnt++; if (Y10 !== 20'd512)  begin err_cnt++; $display("FAIL id_y10: got %0d expected 512", $signed(Y10)); end
    vec_cnt++; if (X00 !== 20'd1024) begin err_cnt++; $display("FAIL id_x00: got %0d expected 1024", $signed(X00)); end
    vec_cnt++; if (X10 !== 20'd512)  begin err_cnt++; $display("FAIL id_x10: got %0d expected 512", $signed(X10)); end
  endtask

  task automatic test_half_gain();
    int cyc;
    drive(512, 0, 0, 512, 1024, 1024, 3072, 0, 1024, 2048);
    start_op();
    wait_done(cyc);
    vec_cnt++; if (cyc !== 5) begin err_cnt++; $display("FAIL half_latency: got %0d expected 5", cyc); end
    vec_cnt++; if (Y00 !== 20'(2048))  begin err_cnt++; $display("FAIL half_y00: got %0d expected 2048", $signed(Y00)); end
    vec_cnt++; if (Y10 !== 20'(-2048)) begin err_cnt++; $display("FAIL half_y10: got %0d expected -2048", $signed(Y10)); end
    vec_cnt++; if (X00 !== 20'(2048))  begin err_cnt++; $display("FAIL half_x00: got %0d expected 2048", $signed(X00)); end
    vec_cnt++; if (X10 !== 20'(0))     begin err_cnt++; $display("FAIL half_x10: got %0d expected 0", $signed(X10)); end
  endtask

  // Tiny gain: products of +-1 floor to -1 and 0 respectively.
  task automatic test_truncation();
    int cyc;
    drive(1, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    start_op();
    wait_done(cyc);
    vec_cnt++; if (cyc !== 5) begin err_cnt++; $display("FAIL trunc_latency: got %0d expected 5", cyc); end
    vec_cnt++; if (Y00 !== 20'(-1)) begin err_cnt++; $display("FAIL trunc_y00: got %0d expected -1", $signed(Y00)); end
    vec_cnt++; if (X00 !== 20'(-1)) begin err_cnt++; $display("FAIL trunc_x00: got %0d expected -1", $signed(X00)); end
    vec_cnt++; if (X10 !== 20'(0))  begin err_cnt++; $display("FAIL trunc_x10: got %0d expected 0", $signed(X10)); end
  endtask

  task automatic test_overflow();
    int cyc;
    drive(1024, 0, 0, 1024, 0, 0, 524287, -524288, -524288, 1);
    start_op();
    wait_done(cyc);
    vec_cnt++; if (cyc !== 5) begin err_cnt++; $display("FAIL ovf_latency: got %0d expected 5", cyc); end
    vec_cnt++; if (Y00 !== 20'(OVF_Y00)) begin err_cnt++; $display("FAIL ovf_y00: got %0d expected %0d", $signed(Y00), OVF_Y00); end
    vec_cnt++; if (Y10 !== 20'(OVF_Y10)) begin err_cnt++; $display("FAIL ovf_y10: got %0d expected %0d", $signed(Y10), OVF_Y10); end
    vec_cnt++; if (X00 !== 20'(OVF_Y00)) begin err_cnt++; $display("FAIL ovf_x00_follow: got %0d expected %0d", $signed(X00), OVF_Y00); end
    vec_cnt++; if (X10 !== 20'(OVF_Y10)) begin err_cnt++; $display("FAIL ovf_x10_follow: got %0d expected %0d", $signed(X10), OVF_Y10); end
    drive(1024, 0, 0, 1024, 524287, 0, 1024, 0, 0, 0);
    start_op();
    wait_done(cyc);
    vec_cnt++; if (Y00 !== 20'(1024))    begin err_cnt++; $display("FAIL ovfx_y00: got %0d expected 1024", $signed(Y00)); end
    vec_cnt++; if (X00 !== 20'(OVF_X00)) begin err_cnt++; $display("FAIL ovfx_x00: got %0d expected %0d", $signed(X00), OVF_X00); end
    vec_cnt++; if (X10 !== 20'(0))       begin err_cnt++; $display("FAIL ovfx_x10: got %0d expected 0", $signed(X10)); end
  endtask

  // A start pulse while busy (with different inputs) must be dropped.
  task automatic test_busy_ignore();
    int cyc, busy_after;
    drive(512, 0, 0, 512, 1024, 1024, 3072, 0, 1024, 2048);
    start_op();
    @(negedge clk);
    drive(1024, 0, 0, 1024, 0, 0, 2048, 1024, 1024, 512);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    vec_cnt++; if (cyc !== 3) begin err_cnt++; $display("FAIL ign_latency: got %0d expected 3", cyc); end
    vec_cnt++; if (Y10 !== 20'(-2048)) begin err_cnt++; $display("FAIL ign_y10: got %0d expected -2048", $signed(Y10)); end
    vec_cnt++; if (X00 !== 20'(2048))  begin err_cnt++; $display("FAIL ign_x00: got %0d expected 2048", $signed(X00)); end
    vec_cnt++; if (X10 !== 20'(0))     begin err_cnt++; $display("FAIL ign_x10: got %0d expected 0", $signed(X10)); end
    busy_after = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) busy_after++;
    end
    vec_cnt++; if (busy_after !== 0) begin err_cnt++; $display("FAIL ign_no_queue: got %0d active cycles expected 0", busy_after); end
  endtask

  // start held high: a new op is taken in every done cycle.
  task automatic test_back_to_back();
    int bad_done, cyc;
    logic [N-1:0] x00_5, x10_5, x00_11, x10_11;
    bad_done = 0;
    x00_5 = '0; x10_5 = '0; x00_11 = '0; x10_11 = '0;
    drive(512, 0, 0, 512, 1024, 1024, 3072, 0, 1024, 2048);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      if (i == 1) drive(1024, 0, 0, 1024, 0, 0, 2048, 1024, 1024, 512);
      if (done !== ((i == 5) || (i == 11) || (i == 17))) bad_done++;
      if (i == 5)  begin x00_5 = X00;  x10_5 = X10;  end
      if (i == 11) begin x00_11 = X00; x10_11 = X10; end
      @(negedge clk);
    end
    start = 1'b0;
    vec_cnt++; if (bad_done !== 0) begin err_cnt++; $display("FAIL b2b_done_pattern: got %0d wrong cycles expected 0", bad_done); end
    vec_cnt++; if (x00_5 !== 20'(2048))  begin err_cnt++; $display("FAIL b2b_op1_x00: got %0d expected 2048", $signed(x00_5)); end
    vec_cnt++; if (x10_5 !== 20'(0))     begin err_cnt++; $display("FAIL b2b_op1_x10: got %0d expected 0", $signed(x10_5)); end
    vec_cnt++; if (x00_11 !== 20'(1024)) begin err_cnt++; $display("FAIL b2b_op2_x00: got %0d expected 1024", $signed(x00_11)); end
    vec_cnt++; if (x10_11 !== 20'(512))  begin err_cnt++; $display("FAIL b2b_op2_x10: got %0d expected 512", $signed(x10_11)); end
    wait_done(cyc);
    vec_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL b2b_drain: got done=%0b expected 1", done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, stray_done;
    drive(512, 0, 0, 512, 1024, 1024, 3072, 0, 1024, 2048);
    start_op();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL mid_done: got %0b expected 0", done); end
    vec_cnt++; if ({Y00, Y10, X00, X10} !== 80'd0) begin err_cnt++; $display("FAIL mid_outputs: got %h expected 0", {Y00, Y10, X00, X10}); end
    stray_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done !== 1'b0) stray_done++;
    end
    vec_cnt++; if (stray_done !== 0) begin err_cnt++; $display("FAIL mid_no_done: got %0d pulses expected 0", stray_done); end
    drive(1024, 0, 0, 1024, 0, 0, 2048, 1024, 1024, 512);
    start_op();
    wait_done(cyc);
    vec_cnt++; if (cyc !== 5) begin err_cnt++; $display("FAIL mid_fresh_latency: got %0d expected 5", cyc); end
    vec_cnt++; if (Y00 !== 20'(1024)) begin err_cnt++; $display("FAIL mid_fresh_y00: got %0d expected 1024", $signed(Y00)); end
    vec_cnt++; if (Y10 !== 20'(512))  begin err_cnt++; $display("FAIL mid_fresh_y10: got %0d expected 512", $signed(Y10)); end
    vec_cnt++; if (X00 !== 20'(1024)) begin err_cnt++; $display("FAIL mid_fresh_x00: got %0d expected 1024", $signed(X00)); end
    vec_cnt++; if (X10 !== 20'(512))  begin err_cnt++; $display("FAIL mid_fresh_x10: got %0d expected 512", $signed(X10)); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_half_gain();
    test_truncation();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
